// File: rtl/adam_jtag_dtm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adam_jtag_dtm_pkg
// Description : Shared constants for the JTAG debug transport module: IR
//               codes, DMI op/status encodings, DMI FSM encoding and the
//               IEEE 1149.1 TAP state type with its next-state function.
// Revision    : 1.0 - initial release
// ============================================================================
package adam_jtag_dtm_pkg;

    // Instruction register codes
    localparam logic [4:0] c_ir_idcode  = 5'h01;
    localparam logic [4:0] c_ir_dtmcs   = 5'h10;
    localparam logic [4:0] c_ir_dmi     = 5'h11;
    localparam logic [4:0] c_ir_capture = 5'b00001;

    // DMI request ops
    localparam logic [1:0] c_dmi_op_nop   = 2'd0;
    localparam logic [1:0] c_dmi_op_read  = 2'd1;
    localparam logic [1:0] c_dmi_op_write = 2'd2;

    // DMI status (sticky dmistat / captured op)
    localparam logic [1:0] c_dmi_stat_ok     = 2'd0;
    localparam logic [1:0] c_dmi_stat_failed = 2'd2;
    localparam logic [1:0] c_dmi_stat_busy   = 2'd3;

    // DMI transaction FSM encoding
    localparam logic [1:0] c_dmi_fsm_idle = 2'd0;
    localparam logic [1:0] c_dmi_fsm_req  = 2'd1;
    localparam logic [1:0] c_dmi_fsm_rsp  = 2'd2;

    typedef enum logic [3:0] {
        TAP_TLR    = 4'd0,
        TAP_RTI    = 4'd1,
        TAP_SEL_DR = 4'd2,
        TAP_CAP_DR = 4'd3,
        TAP_SH_DR  = 4'd4,
        TAP_EX1_DR = 4'd5,
        TAP_PAU_DR = 4'd6,
        TAP_EX2_DR = 4'd7,
        TAP_UPD_DR = 4'd8,
        TAP_SEL_IR = 4'd9,
        TAP_CAP_IR = 4'd10,
        TAP_SH_IR  = 4'd11,
        TAP_EX1_IR = 4'd12,
        TAP_PAU_IR = 4'd13,
        TAP_EX2_IR = 4'd14,
        TAP_UPD_IR = 4'd15
    } tap_state_e;

    // Standard TAP transition on a tck rising edge
    function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
        case (s)
            TAP_TLR:    return tms ? TAP_TLR    : TAP_RTI;
            TAP_RTI:    return tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_DR: return tms ? TAP_SEL_IR : TAP_CAP_DR;
            TAP_CAP_DR: return tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_SH_DR:  return tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_EX1_DR: return tms ? TAP_UPD_DR : TAP_PAU_DR;
            TAP_PAU_DR: return tms ? TAP_EX2_DR : TAP_PAU_DR;
            TAP_EX2_DR: return tms ? TAP_UPD_DR : TAP_SH_DR;
            TAP_UPD_DR: return tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_IR: return tms ? TAP_TLR    : TAP_CAP_IR;
            TAP_CAP_IR: return tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_SH_IR:  return tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_EX1_IR: return tms ? TAP_UPD_IR : TAP_PAU_IR;
            TAP_PAU_IR: return tms ? TAP_EX2_IR : TAP_PAU_IR;
            TAP_EX2_IR: return tms ? TAP_UPD_IR : TAP_SH_IR;
            TAP_UPD_IR: return tms ? TAP_SEL_DR : TAP_RTI;
            default:    return TAP_TLR;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/adam_jtag_tap.sv
`default_nettype none
// ============================================================================
// Module      : adam_jtag_tap
// Description : IEEE 1149.1 TAP controller state machine plus the 5-bit
//               instruction register, stepped by a one-clk tck-rise strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module adam_jtag_tap
    import adam_jtag_dtm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_tck_rise,
    input  logic       i_tms,
    input  logic       i_tdi,
    output tap_state_e o_state,
    output logic [4:0] o_ir,
    output logic       o_ir_lsb
);

    tap_state_e r_state;
    tap_state_e w_state_next;
    logic [4:0] r_ir;
    logic [4:0] r_ir_sr;

    // TAP state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= TAP_TLR;
        else     r_state <= w_state_next;
    end

    // Next state: advance only on a tck rising edge
    always_comb begin
        w_state_next = r_state;
        if (i_tck_rise) w_state_next = tap_next(r_state, i_tms);
    end

    // IR capture/shift/update, forced to IDCODE while in Test-Logic-Reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ir    <= c_ir_idcode;
            r_ir_sr <= 5'd0;
        end else if (r_state == TAP_TLR) begin
            r_ir <= c_ir_idcode;
        end else if (i_tck_rise) begin
            case (r_state)
                TAP_CAP_IR: r_ir_sr <= c_ir_capture;
                TAP_SH_IR:  r_ir_sr <= {i_tdi, r_ir_sr[4:1]};
                TAP_UPD_IR: r_ir    <= r_ir_sr;
                default: ;
            endcase
        end
    end

    assign o_state  = r_state;
    assign o_ir     = r_ir;
    assign o_ir_lsb = r_ir_sr[0];

endmodule
`default_nettype wire

// File: rtl/adam_jtag_dtm.sv
`default_nettype none
// ============================================================================
// Module      : adam_jtag_dtm
// Description : JTAG debug transport module. Oversamples tck/tms/tdi with the
//               system clock, runs the TAP, exposes IDCODE/DTMCS/DMI/BYPASS
//               data registers and issues single outstanding DMI requests.
//               Define ADAM_DTM_SYNC_EN to add 2-flop input synchronizers.
// Revision    : 1.0 - initial release
// ============================================================================
module adam_jtag_dtm
    import adam_jtag_dtm_pkg::*;
#(
    parameter logic [31:0] IDCODE = 32'h0000_0001,
    parameter int          ABITS  = 7,
    parameter int          IDLE   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pause_req,
    output logic             pause_ack,
    input  logic             jtag_tck,
    input  logic             jtag_tms,
    input  logic             jtag_tdi,
    output logic             jtag_tdo,
    output logic             dmi_req_valid,
    input  logic             dmi_req_ready,
    output logic [ABITS-1:0] dmi_req_addr,
    output logic [31:0]      dmi_req_data,
    output logic [1:0]       dmi_req_op,
    input  logic             dmi_rsp_valid,
    output logic             dmi_rsp_ready,
    input  logic [31:0]      dmi_rsp_data,
    input  logic [1:0]       dmi_rsp_op
);

    // DMI is the widest data register, so it sets the shifter width
    localparam int c_dmi_w = ABITS + 34;

    logic [2:0] r_pin;                 // {tck, tms, tdi}
    logic       r_tck_prev, r_tck_rise, r_tck_fall, r_tms, r_tdi;

`ifdef ADAM_DTM_SYNC_EN
    logic [2:0] r_sync1, r_sync2;

    // Two-flop synchronizer ahead of the input register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 3'd0;
            r_sync2 <= 3'd0;
            r_pin   <= 3'd0;
        end else begin
            r_sync1 <= {jtag_tck, jtag_tms, jtag_tdi};
            r_sync2 <= r_sync1;
            r_pin   <= r_sync2;
        end
    end
`else
    // Single input register
    always_ff @(posedge clk) begin
        if (rst) r_pin <= 3'd0;
        else     r_pin <= {jtag_tck, jtag_tms, jtag_tdi};
    end
`endif

    // Edge detect; strobes and the sampled tms/tdi act one clk later
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tck_prev <= 1'b0;
            r_tck_rise <= 1'b0;
            r_tck_fall <= 1'b0;
            r_tms      <= 1'b0;
            r_tdi      <= 1'b0;
        end else begin
            r_tck_prev <= r_pin[2];
            r_tck_rise <= r_pin[2] & ~r_tck_prev;
            r_tck_fall <= ~r_pin[2] & r_tck_prev;
            r_tms      <= r_pin[1];
            r_tdi      <= r_pin[0];
        end
    end

    tap_state_e w_tap_state;
    logic [4:0] w_ir;
    logic       w_ir_lsb;

    adam_jtag_tap u_tap (
        .clk        (clk),
        .rst        (rst),
        .i_tck_rise (r_tck_rise),
        .i_tms      (r_tms),
        .i_tdi      (r_tdi),
        .o_state    (w_tap_state),
        .o_ir       (w_ir),
        .o_ir_lsb   (w_ir_lsb)
    );

    logic [c_dmi_w-1:0] r_dr, w_dr_capture, w_dr_shift;
    logic [1:0]         r_dmistat, r_dmi_state, w_dmi_next, w_capture_op, w_upd_op;
    logic [ABITS-1:0]   r_req_addr;
    logic [31:0]        r_req_data, r_rsp_data;
    logic [1:0]         r_req_op;
    logic               r_tdo, r_pause_ack;
    logic               w_busy, w_upd_dr, w_upd_dmi, w_upd_dtmcs;
    logic               w_launch, w_hard_reset, w_rsp_done;

    assign w_busy       = (r_dmi_state != c_dmi_fsm_idle);
    assign w_upd_dr     = r_tck_rise && (w_tap_state == TAP_UPD_DR);
    assign w_upd_dmi    = w_upd_dr && (w_ir == c_ir_dmi);
    assign w_upd_dtmcs  = w_upd_dr && (w_ir == c_ir_dtmcs);
    assign w_upd_op     = r_dr[1:0];
    assign w_hard_reset = w_upd_dtmcs && r_dr[17];
    assign w_rsp_done   = (r_dmi_state == c_dmi_fsm_rsp) && dmi_rsp_valid;
    assign w_launch     = w_upd_dmi && !w_busy && (r_dmistat == c_dmi_stat_ok) && !pause_req &&
                          ((w_upd_op == c_dmi_op_read) || (w_upd_op == c_dmi_op_write));

    // Capture values for the selected data register
    always_comb begin
        w_capture_op = c_dmi_stat_ok;
        if (r_dmistat != c_dmi_stat_ok) w_capture_op = r_dmistat;
        else if (w_busy)                w_capture_op = c_dmi_stat_busy;
        w_dr_capture = '0;
        case (w_ir)
            c_ir_idcode: w_dr_capture[31:0] = IDCODE;
            c_ir_dtmcs:  w_dr_capture[31:0] = {17'd0, 3'(IDLE), r_dmistat, 6'(ABITS), 4'd1};
            c_ir_dmi:    w_dr_capture = {r_req_addr, r_rsp_data, w_capture_op};
            default: ;
        endcase
    end

    // Shift right; tdi enters at the MSB of the selected register length
    always_comb begin
        w_dr_shift = r_dr >> 1;
        case (w_ir)
            c_ir_idcode, c_ir_dtmcs: w_dr_shift[31] = r_tdi;
            c_ir_dmi:                w_dr_shift[c_dmi_w-1] = r_tdi;
            default:                 w_dr_shift[0] = r_tdi;
        endcase
    end

    // DR shifter, tdo, request/response registers and pause acknowledge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dr        <= '0;
            r_tdo       <= 1'b0;
            r_req_addr  <= '0;
            r_req_data  <= 32'd0;
            r_req_op    <= c_dmi_op_nop;
            r_rsp_data  <= 32'd0;
            r_pause_ack <= 1'b0;
        end else begin
            if (r_tck_rise) begin
                if (w_tap_state == TAP_CAP_DR)     r_dr <= w_dr_capture;
                else if (w_tap_state == TAP_SH_DR) r_dr <= w_dr_shift;
            end
            if (r_tck_fall) begin
                if (w_tap_state == TAP_SH_DR)      r_tdo <= r_dr[0];
                else if (w_tap_state == TAP_SH_IR) r_tdo <= w_ir_lsb;
                else                               r_tdo <= 1'b0;
            end
            if (w_launch) begin
                r_req_addr <= r_dr[c_dmi_w-1:34];
                r_req_data <= r_dr[33:2];
                r_req_op   <= w_upd_op;
            end
            if (w_rsp_done && !w_hard_reset) r_rsp_data <= dmi_rsp_data;
            r_pause_ack <= pause_req && (w_dmi_next == c_dmi_fsm_idle);
        end
    end

    // Sticky dmistat: resets clear, busy collisions and failed responses set
    always_ff @(posedge clk) begin
        if (rst)                                    r_dmistat <= c_dmi_stat_ok;
        else if (w_hard_reset || (w_upd_dtmcs && r_dr[16]))
                                                    r_dmistat <= c_dmi_stat_ok;
        else if (w_upd_dmi && w_busy)               r_dmistat <= c_dmi_stat_busy;
        else if (w_rsp_done && (dmi_rsp_op != 2'd0)) r_dmistat <= c_dmi_stat_failed;
    end

    // DMI transaction state register
    always_ff @(posedge clk) begin
        if (rst) r_dmi_state <= c_dmi_fsm_idle;
        else     r_dmi_state <= w_dmi_next;
    end

    // DMI next state: IDLE -> REQ until ready -> RSP until valid -> IDLE
    always_comb begin
        w_dmi_next = r_dmi_state;
        case (r_dmi_state)
            c_dmi_fsm_idle: if (w_launch)      w_dmi_next = c_dmi_fsm_req;
            c_dmi_fsm_req:  if (dmi_req_ready) w_dmi_next = c_dmi_fsm_rsp;
            c_dmi_fsm_rsp:  if (dmi_rsp_valid) w_dmi_next = c_dmi_fsm_idle;
            default:                           w_dmi_next = c_dmi_fsm_idle;
        endcase
        if (w_hard_reset) w_dmi_next = c_dmi_fsm_idle;
    end

    assign dmi_req_valid = (r_dmi_state == c_dmi_fsm_req);
    assign dmi_rsp_ready = (r_dmi_state == c_dmi_fsm_rsp);
    assign dmi_req_addr  = r_req_addr;
    assign dmi_req_data  = r_req_data;
    assign dmi_req_op    = r_req_op;
    assign jtag_tdo      = r_tdo;
    assign pause_ack     = r_pause_ack;

endmodule
`default_nettype wire

// File: tb/tb_adam_jtag_dtm.sv
`default_nettype none
// ============================================================================
// Module      : tb_adam_jtag_dtm
// Description : Self-checking bench for adam_jtag_dtm: table of DR scans plus
//               hand-written DMI write/read/busy/failure/abort/pause/reset
//               sequences against a small DMI responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adam_jtag_dtm;

    localparam int c_half = 8;   // clk cycles per tck half period

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pause_req = 1'b0;
    logic        pause_ack;
    logic        jtag_tck = 1'b0, jtag_tms = 1'b0, jtag_tdi = 1'b0;
    logic        jtag_tdo;
    logic        dmi_req_valid;
    logic        dmi_req_ready = 1'b0;
    logic [6:0]  dmi_req_addr;
    logic [31:0] dmi_req_data;
    logic [1:0]  dmi_req_op;
    logic        dmi_rsp_valid = 1'b0;
    logic        dmi_rsp_ready;
    logic [31:0] dmi_rsp_data = 32'd0;
    logic [1:0]  dmi_rsp_op = 2'd0;

    always #5 clk = ~clk;

    adam_jtag_dtm dut (
        .clk           (clk),
        .rst           (rst),
        .pause_req     (pause_req),
        .pause_ack     (pause_ack),
        .jtag_tck      (jtag_tck),
        .jtag_tms      (jtag_tms),
        .jtag_tdi      (jtag_tdi),
        .jtag_tdo      (jtag_tdo),
        .dmi_req_valid (dmi_req_valid),
        .dmi_req_ready (dmi_req_ready),
        .dmi_req_addr  (dmi_req_addr),
        .dmi_req_data  (dmi_req_data),
        .dmi_req_op    (dmi_req_op),
        .dmi_rsp_valid (dmi_rsp_valid),
        .dmi_rsp_ready (dmi_rsp_ready),
        .dmi_rsp_data  (dmi_rsp_data),
        .dmi_rsp_op    (dmi_rsp_op)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Responder state shared with the main sequence
    int          req_count = 0;
    int          req_wait  = 0;
    logic [6:0]  seen_addr = 7'd0;
    logic [31:0] seen_data = 32'd0;
    logic [1:0]  seen_op   = 2'd0;
    logic        rsp_stall = 1'b0;
    logic [31:0] rsp_value = 32'd0;
    logic [1:0]  rsp_status = 2'd0;

    // DMI responder: ready after two waiting cycles, response when not stalled
    initial begin
        forever begin
            @(negedge clk);
            dmi_rsp_valid = 1'b0;
            if (dmi_req_valid) begin
                if (req_wait == 2) begin
                    dmi_req_ready = 1'b1;
                    req_wait  = 0;
                    req_count = req_count + 1;
                    seen_addr = dmi_req_addr;
                    seen_data = dmi_req_data;
                    seen_op   = dmi_req_op;
                end else begin
                    dmi_req_ready = 1'b0;
                    req_wait = req_wait + 1;
                end
            end else begin
                dmi_req_ready = 1'b0;
                req_wait = 0;
            end
            if (dmi_rsp_ready && !rsp_stall) begin
                dmi_rsp_valid = 1'b1;
                dmi_rsp_data  = rsp_value;
                dmi_rsp_op    = rsp_status;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    task automatic jtag_clk(input logic tms_v, input logic tdi_v, output logic tdo_v);
        jtag_tms = tms_v;
        jtag_tdi = tdi_v;
        repeat (c_half) @(negedge clk);
        tdo_v = jtag_tdo;
        jtag_tck = 1'b1;
        repeat (c_half) @(negedge clk);
        jtag_tck = 1'b0;
    endtask

    task automatic shift_ir(input logic [4:0] ir, output logic [4:0] cap);
        logic t;
        cap = 5'd0;
        jtag_clk(1'b1, 1'b0, t);
        jtag_clk(1'b1, 1'b0, t);
        jtag_clk(1'b0, 1'b0, t);
        jtag_clk(1'b0, 1'b0, t);
        for (int i = 0; i < 5; i++) begin
            jtag_clk(i == 4, ir[i], t);
            cap[i] = t;
        end
        jtag_clk(1'b1, 1'b0, t);
        jtag_clk(1'b0, 1'b0, t);
    endtask

    task automatic shift_dr(input logic [63:0] din, input int len, output logic [63:0] dout);
        logic t;
        dout = 64'd0;
        jtag_clk(1'b1, 1'b0, t);
        jtag_clk(1'b0, 1'b0, t);
        jtag_clk(1'b0, 1'b0, t);
        for (int i = 0; i < len; i++) begin
            jtag_clk(i == len - 1, din[i], t);
            dout[i] = t;
        end
        jtag_clk(1'b1, 1'b0, t);
        jtag_clk(1'b0, 1'b0, t);
    endtask

    task automatic dmi_scan(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op,
                            output logic [63:0] dout);
        shift_dr({23'd0, a, d, op}, 41, dout);
    endtask

    function automatic logic [63:0] dmi_word(input logic [6:0] a, input logic [31:0] d,
                                             input logic [1:0] op);
        return {23'd0, a, d, op};
    endfunction

    typedef struct {
        string       name;
        logic [4:0]  ir;
        int          len;
        logic [63:0] din;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic set_vec(input int idx, input string name, input logic [4:0] ir, input int len,
                           input logic [63:0] din, input logic [63:0] exp);
        vecs[idx].name = name;
        vecs[idx].ir   = ir;
        vecs[idx].len  = len;
        vecs[idx].din  = din;
        vecs[idx].exp  = exp;
    endtask

    initial begin
        logic [4:0]  cap;
        logic [63:0] out;
        logic        t;
        int          base;

        set_vec(0, "idcode",     5'h01, 32, 64'h0,           64'h0000_0001);
        set_vec(1, "dtmcs",      5'h10, 32, 64'h0,           64'h0000_1071);
        set_vec(2, "bypass_1f",  5'h1F, 8,  64'hA5,          64'h4A);
        set_vec(3, "bypass_02",  5'h02, 4,  64'hF,           64'hE);
        set_vec(4, "idcode_len", 5'h01, 40, 64'hFF_FFFF_FFFF, 64'hFF_0000_0001);
        set_vec(5, "dtmcs_len",  5'h10, 36, 64'h5,           64'h5_0000_1071);
        set_vec(6, "dmi_init",   5'h11, 41, 64'h0,           64'h0);

        // Reset state
        repeat (4) @(negedge clk);
        check("rst_tdo",       {63'd0, jtag_tdo},      64'd0);
        check("rst_req_valid", {63'd0, dmi_req_valid}, 64'd0);
        check("rst_rsp_ready", {63'd0, dmi_rsp_ready}, 64'd0);
        check("rst_pause_ack", {63'd0, pause_ack},     64'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // TMS=1 x5 then Run-Test-Idle; IR is IDCODE without any IR scan
        for (int i = 0; i < 5; i++) jtag_clk(1'b1, 1'b0, t);
        jtag_clk(1'b0, 1'b0, t);
        shift_dr(64'd0, 32, out);
        check("idcode_after_tlr", out, 64'h0000_0001);
        shift_ir(5'h01, cap);
        check("ir_capture", {59'd0, cap}, 64'h01);

        // Table of DR scans
        for (int i = 0; i < 7; i++) begin
            shift_ir(vecs[i].ir, cap);
            shift_dr(vecs[i].din, vecs[i].len, out);
            check(vecs[i].name, out, vecs[i].exp);
        end

        // DMI write
        rsp_value = 32'h1234_5678; rsp_status = 2'd0;
        base = req_count;
        dmi_scan(7'h10, 32'hFFFF_FFFF, 2'd2, out);
        repeat (30) @(negedge clk);
        check("wr_count", 64'(req_count - base), 64'd1);
        check("wr_addr",  {57'd0, seen_addr}, 64'h10);
        check("wr_data",  {32'd0, seen_data}, 64'hFFFF_FFFF);
        check("wr_op",    {62'd0, seen_op},   64'd2);
        dmi_scan(7'h00, 32'h0, 2'd0, out);
        check("wr_capture", out, dmi_word(7'h10, 32'h1234_5678, 2'd0));

        // DMI read
        rsp_value = 32'h0000_0382;
        base = req_count;
        dmi_scan(7'h11, 32'h0, 2'd1, out);
        repeat (30) @(negedge clk);
        check("rd_count", 64'(req_count - base), 64'd1);
        check("rd_addr",  {57'd0, seen_addr}, 64'h11);
        check("rd_op",    {62'd0, seen_op},   64'd1);
        dmi_scan(7'h00, 32'h0, 2'd0, out);
        check("rd_capture", out, dmi_word(7'h11, 32'h0000_0382, 2'd0));

        // Busy collision: second update while the responder stalls
        rsp_stall = 1'b1; rsp_value = 32'h0000_ABCD;
        base = req_count;
        dmi_scan(7'h05, 32'h0, 2'd1, out);
        repeat (30) @(negedge clk);
        check("busy_rsp_ready", {63'd0, dmi_rsp_ready}, 64'd1);
        dmi_scan(7'h06, 32'h0, 2'd1, out);
        check("busy_capture_op", {62'd0, out[1:0]}, 64'd3);
        rsp_stall = 1'b0;
        repeat (30) @(negedge clk);
        dmi_scan(7'h00, 32'h0, 2'd0, out);
        check("sticky_busy_op", {62'd0, out[1:0]}, 64'd3);
        dmi_scan(7'h07, 32'h0, 2'd1, out);
        repeat (30) @(negedge clk);
        check("busy_req_count", 64'(req_count - base), 64'd1);
        shift_ir(5'h10, cap);
        shift_dr(64'h0001_0000, 32, out);
        check("dtmcs_dmistat3", out, 64'h0000_1C71);
        shift_dr(64'h0, 32, out);
        check("dtmcs_cleared", out, 64'h0000_1071);
        shift_ir(5'h11, cap);
        dmi_scan(7'h00, 32'h0, 2'd0, out);
        check("after_dmireset", out, dmi_word(7'h05, 32'h0000_ABCD, 2'd0));

        // Failed response
        rsp_status = 2'd2; rsp_value = 32'h0000_DEAD;
        dmi_scan(7'h08, 32'h0, 2'd1, out);
        repeat (30) @(negedge clk);
        rsp_status = 2'd0;
        dmi_scan(7'h00, 32'h0, 2'd0, out);
        check("failed_capture", out, dmi_word(7'h08, 32'h0000_DEAD, 2'd2));
        shift_ir(5'h10, cap);
        shift_dr(64'h0002_0000, 32, out);
        check("dtmcs_dmistat2", out, 64'h0000_1871);
        shift_dr(64'h0, 32, out);
        check("dtmcs_hard_cleared", out, 64'h0000_1071);

        // dmihardreset aborts an outstanding transaction
        shift_ir(5'h11, cap);
        rsp_stall = 1'b1; rsp_value = 32'h0000_5555;
        dmi_scan(7'h09, 32'h0, 2'd1, out);
        repeat (30) @(negedge clk);
        shift_ir(5'h10, cap);
        shift_dr(64'h0002_0000, 32, out);
        repeat (10) @(negedge clk);
        check("abort_rsp_ready", {63'd0, dmi_rsp_ready}, 64'd0);
        rsp_stall = 1'b0;
        shift_ir(5'h11, cap);
        dmi_scan(7'h00, 32'h0, 2'd0, out);
        check("abort_capture", out, dmi_word(7'h09, 32'h0000_DEAD, 2'd0));

        // Pause handshake around an outstanding read
        rsp_stall = 1'b1; rsp_value = 32'h0000_0077;
        dmi_scan(7'h0A, 32'h0, 2'd1, out);
        repeat (30) @(negedge clk);
        pause_req = 1'b1;
        repeat (20) @(negedge clk);
        check("ack_while_outstanding", {63'd0, pause_ack}, 64'd0);
        rsp_stall = 1'b0;
        repeat (20) @(negedge clk);
        check("ack_after_rsp", {63'd0, pause_ack}, 64'd1);
        base = req_count;
        dmi_scan(7'h0B, 32'h0, 2'd1, out);
        repeat (30) @(negedge clk);
        check("no_req_paused", 64'(req_count - base), 64'd0);
        check("ack_held", {63'd0, pause_ack}, 64'd1);
        pause_req = 1'b0;
        check("ack_before_drop", {63'd0, pause_ack}, 64'd1);
        @(negedge clk);
        check("ack_drop", {63'd0, pause_ack}, 64'd0);
        dmi_scan(7'h00, 32'h0, 2'd0, out);
        check("after_pause_capture", out, dmi_word(7'h0A, 32'h0000_0077, 2'd0));

        // Reset in the middle of a transaction
        rsp_stall = 1'b1; rsp_value = 32'h0000_9999;
        dmi_scan(7'h0C, 32'h0, 2'd1, out);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rsp_stall = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst_rsp_ready", {63'd0, dmi_rsp_ready}, 64'd0);
        check("midrst_req_valid", {63'd0, dmi_req_valid}, 64'd0);
        jtag_clk(1'b0, 1'b0, t);
        shift_dr(64'd0, 32, out);
        check("idcode_after_rst", out, 64'h0000_0001);
        shift_ir(5'h11, cap);
        dmi_scan(7'h00, 32'h0, 2'd0, out);
        check("dmi_after_rst", out, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
